fir_cfg_seq: RTL and testbench

- Front-end controller for the 3-parallel 8-bit FIR (`full_FIR`).
- Input side: packs a serial sample stream (valid/ready) into 3-sample blocks and drives the filter's DIN0..DIN2/VIN.
- Config side: owns coefficients b0..b8 through a shadow bank. On commit, it completes the partial block, drains the filter pipeline, then swaps the shadow bank in, so the filter never sees a coefficient change mid-block.

---
 rtl/fir_cfg_seq.sv | 157 +++++++++++++++
 tb/tb_fir_cfg_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_cfg_seq.sv
// Front-end sequencer for the 3-parallel FIR: packs serial samples into 3-sample blocks and
// swaps a shadow coefficient bank in at a block boundary. Define FIR_CFG_READBACK_EN to add CFG_RDATA.
module fir_cfg_seq #(
   parameter int W        = 8,
   parameter int PIPE_LAT = 4
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic [W-1:0] S_DATA,
   input  logic         S_VALID,
   output logic         S_READY,
   input  logic         CFG_WE,
   input  logic [3:0]   CFG_ADDR,
   input  logic [W-1:0] CFG_DATA,
   input  logic         CFG_COMMIT,
   output logic         CFG_BUSY,
   output logic         CFG_DONE,
   output logic [W-1:0] DIN0,
   output logic [W-1:0] DIN1,
   output logic [W-1:0] DIN2,
   output logic         VIN,
`ifdef FIR_CFG_READBACK_EN
   output logic [W-1:0] CFG_RDATA,
`endif
   output logic [W-1:0] b0,
   output logic [W-1:0] b1,
   output logic [W-1:0] b2,
   output logic [W-1:0] b3,
   output logic [W-1:0] b4,
   output logic [W-1:0] b5,
   output logic [W-1:0] b6,
   output logic [W-1:0] b7,
   output logic [W-1:0] b8
);

   localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

   typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_t;

   state_t         state, state_nxt;
   logic [1:0]     cnt;
   logic [W-1:0]   slot0, slot1;
   logic [W-1:0]   shadow [9];
   logic [W-1:0]   active [9];
   logic           pend;
   logic [DW-1:0]  dcnt;
   logic           accept;

   assign accept = S_VALID && S_READY;

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      S_READY   = 1'b0;
      case (state)
         RUN: begin
            S_READY = !(pend && cnt == 2'd0);
            // The cycle spent here with S_READY low is the first stall cycle.
            if (pend && cnt == 2'd0)
               state_nxt = (PIPE_LAT == 1) ? SWAP : DRAIN;
         end
         DRAIN: begin
            // The counter hits zero on the same edge that leaves DRAIN.
            if (dcnt == DW'(1))
               state_nxt = SWAP;
         end
         SWAP:    state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= RUN;
         dcnt  <= '0;
      end else begin
         state <= state_nxt;
         if (state == RUN && state_nxt == DRAIN)
            dcnt <= DW'(PIPE_LAT - 1);
         else if (state == DRAIN)
            dcnt <= dcnt - DW'(1);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt   <= '0;
         slot0 <= '0;
         slot1 <= '0;
         DIN0  <= '0;
         DIN1  <= '0;
         DIN2  <= '0;
         VIN   <= 1'b0;
      end else begin
         VIN <= 1'b0;
         if (accept) begin
            if (cnt == 2'd2) begin
               DIN0 <= slot0;
               DIN1 <= slot1;
               DIN2 <= S_DATA;
               VIN  <= 1'b1;
               cnt  <= '0;
            end else begin
               if (cnt == 2'd0)
                  slot0 <= S_DATA;
               else
                  slot1 <= S_DATA;
               cnt <= cnt + 2'd1;
            end
         end
      end
   end

   // NOTE: both coefficient banks are reset because the filter must see all-zero taps out of reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < 9; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
         pend     <= 1'b0;
         CFG_DONE <= 1'b0;
      end else begin
         CFG_DONE <= 1'b0;
         if (CFG_WE && !pend && CFG_ADDR <= 4'd8)
            shadow[CFG_ADDR] <= CFG_DATA;
         if (state == SWAP) begin
            active   <= shadow;
            pend     <= 1'b0;
            CFG_DONE <= 1'b1;
         end else if (CFG_COMMIT && !pend) begin
            pend <= 1'b1;
         end
      end
   end

`ifdef FIR_CFG_READBACK_EN
   always_comb begin
      CFG_RDATA = '0;
      if (CFG_ADDR <= 4'd8)
         CFG_RDATA = active[CFG_ADDR];
   end
`endif

   assign CFG_BUSY = pend;
   assign b0 = active[0];
   assign b1 = active[1];
   assign b2 = active[2];
   assign b3 = active[3];
   assign b4 = active[4];
   assign b5 = active[5];
   assign b6 = active[6];
   assign b7 = active[7];
   assign b8 = active[8];

endmodule

// File: tb/tb_fir_cfg_seq.sv
// Self-checking bench for fir_cfg_seq: directed scenarios with literal expectations, then random
// traffic compared every cycle against a block/queue-level model of packing and coefficient commit.
module tb_fir_cfg_seq;

   localparam int W        = 8;
   localparam int PIPE_LAT = 4;

   logic         CLK = 1'b0;
   logic         RST;
   logic [W-1:0] S_DATA;
   logic         S_VALID;
   logic         S_READY;
   logic         CFG_WE;
   logic [3:0]   CFG_ADDR;
   logic [W-1:0] CFG_DATA;
   logic         CFG_COMMIT;
   logic         CFG_BUSY;
   logic         CFG_DONE;
   logic [W-1:0] DIN0, DIN1, DIN2;
   logic         VIN;
   logic [W-1:0] b0, b1, b2, b3, b4, b5, b6, b7, b8;
`ifdef FIR_CFG_READBACK_EN
   logic [W-1:0] CFG_RDATA;
`endif

   fir_cfg_seq #(.W(W), .PIPE_LAT(PIPE_LAT)) dut (
      .CLK(CLK), .RST(RST),
      .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
      .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA), .CFG_COMMIT(CFG_COMMIT),
      .CFG_BUSY(CFG_BUSY), .CFG_DONE(CFG_DONE),
      .DIN0(DIN0), .DIN1(DIN1), .DIN2(DIN2), .VIN(VIN),
`ifdef FIR_CFG_READBACK_EN
      .CFG_RDATA(CFG_RDATA),
`endif
      .b0(b0), .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .b6(b6), .b7(b7), .b8(b8)
   );

   always #5 CLK = ~CLK;

   logic [W-1:0] b_act [9];
   assign b_act[0] = b0;
   assign b_act[1] = b1;
   assign b_act[2] = b2;
   assign b_act[3] = b3;
   assign b_act[4] = b4;
   assign b_act[5] = b5;
   assign b_act[6] = b6;
   assign b_act[7] = b7;
   assign b_act[8] = b8;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: samples of the unfinished block, the commit request and a stall counter.
   logic [W-1:0] m_q [$];
   logic [W-1:0] m_shadow [9];
   logic [W-1:0] m_active [9];
   logic [W-1:0] m_din [3];
   bit           m_pend, m_vin, m_done;
   int           m_stall;

   function automatic void model_reset();
      m_q.delete();
      for (int i = 0; i < 9; i++) begin
         m_shadow[i] = '0;
         m_active[i] = '0;
      end
      for (int i = 0; i < 3; i++) m_din[i] = '0;
      m_pend  = 1'b0;
      m_vin   = 1'b0;
      m_done  = 1'b0;
      m_stall = 0;
   endfunction

   // Input is refused only while a commit waits and no block is half-built.
   function automatic bit m_ready();
      return !(m_pend && m_q.size() == 0);
   endfunction

   function automatic void model_step(input bit v, input logic [W-1:0] d, input bit we,
                                      input logic [3:0] a, input logic [W-1:0] wd, input bit c);
      bit rdy    = m_ready();
      bit pend0  = m_pend;
      bit empty0 = (m_q.size() == 0);
      m_vin  = 1'b0;
      m_done = 1'b0;
      if (v && rdy) begin
         m_q.push_back(d);
         if (m_q.size() == 3) begin
            m_din = '{m_q[0], m_q[1], m_q[2]};
            m_vin = 1'b1;
            m_q.delete();
         end
      end
      if (we && !pend0 && a <= 4'd8) m_shadow[a] = wd;
      if (pend0 && empty0) begin
         m_stall++;
         if (m_stall == PIPE_LAT + 1) begin
            m_active = m_shadow;
            m_pend   = 1'b0;
            m_done   = 1'b1;
            m_stall  = 0;
         end
      end else if (c && !pend0) begin
         m_pend = 1'b1;
      end
   endfunction

   task automatic check_regs();
      check("vin", VIN, m_vin);
      check("din0", DIN0, m_din[0]);
      check("din1", DIN1, m_din[1]);
      check("din2", DIN2, m_din[2]);
      check("busy", CFG_BUSY, m_pend);
      check("done", CFG_DONE, m_done);
      for (int i = 0; i < 9; i++) check($sformatf("b%0d", i), b_act[i], m_active[i]);
   endtask

   // One clock cycle: drive after the falling edge, check combinational outputs, step, check registers.
   task automatic cycle(input bit v, input logic [W-1:0] d, input bit we, input logic [3:0] a,
                        input logic [W-1:0] wd, input bit c, output bit rdy);
      S_VALID = v; S_DATA = d; CFG_WE = we; CFG_ADDR = a; CFG_DATA = wd; CFG_COMMIT = c;
      #1;
      rdy = S_READY;
      check("s_ready", S_READY, m_ready());
`ifdef FIR_CFG_READBACK_EN
      check("rdata", CFG_RDATA, (a <= 4'd8) ? m_active[a] : 8'd0);
`endif
      model_step(v, d, we, a, wd, c);
      @(negedge CLK);
      check_regs();
   endtask

   task automatic idle(input int n);
      bit r;
      for (int k = 0; k < n; k++) cycle(1'b0, '0, 1'b0, 4'd0, '0, 1'b0, r);
   endtask

   // Reset raised in the middle of a cycle with a valid sample on the input.
   task automatic reset_mid();
      S_VALID = 1'b1; S_DATA = 8'hC3; CFG_ADDR = 4'd0; CFG_WE = 1'b0; CFG_COMMIT = 1'b0;
      #2 RST = 1'b1;
      #1;
      check("rst_vin", VIN, 1'b0);
      check("rst_din0", DIN0, 8'h00);
      check("rst_din1", DIN1, 8'h00);
      check("rst_din2", DIN2, 8'h00);
      check("rst_done", CFG_DONE, 1'b0);
      check("rst_busy", CFG_BUSY, 1'b0);
      for (int i = 0; i < 9; i++) check($sformatf("rst_b%0d", i), b_act[i], 8'h00);
`ifdef FIR_CFG_READBACK_EN
      check("rst_rdata", CFG_RDATA, 8'h00);
`endif
      @(negedge CLK);
      RST = 1'b0;
      S_VALID = 1'b0;
      model_reset();
   endtask

   // Counts consecutive cycles with S_READY low (bounded) and the CFG_DONE pulses seen meanwhile.
   task automatic measure_stall(output int n_stall, output int n_done);
      bit r;
      n_stall = 0;
      n_done  = 0;
      for (int k = 0; k < 20; k++) begin
         cycle(1'b0, '0, 1'b0, 4'd0, '0, 1'b0, r);
         if (r) break;
         n_stall++;
         if (CFG_DONE) n_done++;
      end
   endtask

   initial begin
      bit r;
      int ns, nd;
      RST = 1'b1;
      S_VALID = 1'b0; S_DATA = '0; CFG_WE = 1'b0; CFG_ADDR = '0; CFG_DATA = '0; CFG_COMMIT = 1'b0;
      model_reset();
      @(negedge CLK);
      RST = 1'b0;
      check_regs();

      // Partial block, then reset mid-cycle: the leftover samples must be discarded.
      cycle(1'b1, 8'hAA, 1'b0, 4'd0, '0, 1'b0, r);
      cycle(1'b1, 8'hBB, 1'b0, 4'd0, '0, 1'b0, r);
      reset_mid();
      idle(3);

      // Stream 1..6: blocks (1,2,3) and (4,5,6).
      for (int k = 1; k <= 6; k++) begin
         cycle(1'b1, 8'(k), 1'b0, 4'd0, '0, 1'b0, r);
         check("stream_ready", r, 1'b1);
         if (k == 3 || k == 6) begin
            check("blk_vin", VIN, 1'b1);
            check("blk_din0", DIN0, 8'(k - 2));
            check("blk_din1", DIN1, 8'(k - 1));
            check("blk_din2", DIN2, 8'(k));
         end else begin
            check("blk_vin_low", VIN, 1'b0);
         end
      end

      // Load shadow with 1..9 and commit at a block boundary.
      for (int k = 0; k < 9; k++) cycle(1'b0, '0, 1'b1, 4'(k), 8'(k + 1), 1'b0, r);
      check("pre_commit_b0", b0, 8'h00);
      cycle(1'b0, '0, 1'b0, 4'd0, '0, 1'b1, r);
      check("commit_ready", r, 1'b1);
      check("commit_busy", CFG_BUSY, 1'b1);
      measure_stall(ns, nd);
      check("stall_len", 32'(ns), 32'(PIPE_LAT + 1));
      check("done_pulses", 32'(nd), 32'd1);
      for (int i = 0; i < 9; i++) check($sformatf("swap_b%0d", i), b_act[i], 8'(i + 1));

      // Commit one sample into a block, with a same-cycle write to b4.
      cycle(1'b1, 8'h10, 1'b0, 4'd0, '0, 1'b0, r);
      check("b_acc1", r, 1'b1);
      cycle(1'b1, 8'h11, 1'b1, 4'd4, 8'hA5, 1'b1, r);
      check("b_acc2", r, 1'b1);
      cycle(1'b1, 8'h22, 1'b0, 4'd0, '0, 1'b0, r);
      check("b_acc3", r, 1'b1);
      check("b_vin", VIN, 1'b1);
      check("b_din0", DIN0, 8'h10);
      check("b_din1", DIN1, 8'h11);
      check("b_din2", DIN2, 8'h22);
      check("b_b4_hold", b4, 8'h05);
      measure_stall(ns, nd);
      check("b_stall_len", 32'(ns), 32'(PIPE_LAT + 1));
      check("b_done", 32'(nd), 32'd1);
      check("b_b4_new", b4, 8'hA5);

      // Out-of-range write and a write while busy are both dropped.
      cycle(1'b0, '0, 1'b1, 4'd12, 8'h55, 1'b0, r);
      cycle(1'b0, '0, 1'b0, 4'd0, '0, 1'b1, r);
      cycle(1'b0, '0, 1'b1, 4'd0, 8'h77, 1'b0, r);
      check("c_busy_ready", r, 1'b0);
      measure_stall(ns, nd);
      check("c_stall_rest", 32'(ns), 32'(PIPE_LAT));
      check("c_b0", b0, 8'h01);
      check("c_b3", b3, 8'h04);
      check("c_b4", b4, 8'hA5);
      check("c_b8", b8, 8'h09);

      // Reset during DRAIN aborts the swap.
      cycle(1'b0, '0, 1'b1, 4'd0, 8'h7F, 1'b0, r);
      cycle(1'b0, '0, 1'b0, 4'd0, '0, 1'b1, r);
      idle(2);
      reset_mid();
      idle(PIPE_LAT + 3);
      check("d_b0", b0, 8'h00);

      // Random traffic against the model, with one reset in the middle.
      for (int i = 0; i < 1500; i++) begin
         if (i == 700) reset_mid();
         cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 2,
               4'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 19) == 0, r);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
